bit_serial_mult_sat: RTL and testbench

//  Parametrised bit-serial sign-magnitude fixed-point multiplier for the NN accelerator datapath.

---
 rtl/bit_serial_mult_sat_if.sv | 29 ++
 rtl/bit_serial_mult_sat.sv | 134 +++++++++++++
 tb/tb_bit_serial_mult_sat.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_mult_sat_if.sv
// Purpose: operand, weight-stream and result signals of the bit-serial multiplier.
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready handshakes, w_valid low stalls the weight stream.
interface bit_serial_mult_sat_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_neuron;
   logic              w_valid;
   logic              w_bit;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sat;
   logic              busy;

   // Producer/consumer side (drives operands, weight bits and out_ready).
   modport master (
      output in_valid, in_neuron, w_valid, w_bit, out_ready,
      input  in_ready, out_valid, out_data, out_sat, busy
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in_neuron, w_valid, w_bit, out_ready,
      output in_ready, out_valid, out_data, out_sat, busy
   );
endinterface

// File: rtl/bit_serial_mult_sat.sv
// Purpose: sign-magnitude neuron x bit-serial weight, rounded half-up and saturated to neuron format.
// Latency: out_valid first high WGT_W+2 cycles after operand accept, plus one per w_valid-low cycle.
// Backpressure: in_ready only in IDLE; result and out_valid held until out_ready; w_valid low holds state.
module bit_serial_mult_sat #(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 10,
   parameter int WGT_W   = 16,
   parameter int WFRAC_W = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   bit_serial_mult_sat_if.slave   bus
);
   localparam int MAG_W = DATA_W - 1;
   localparam int ACC_W = (DATA_W - 1) + (WGT_W - 1);
   localparam int SUM_W = ACC_W + 1;
   localparam int CNT_W = (WGT_W > 2) ? $clog2(WGT_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WGT_W - 2);

   // The product keeps the neuron's FRAC_W fraction bits, so both formats must be sane.
   if (FRAC_W >= DATA_W || WFRAC_W >= WGT_W) begin : g_param_check
      $error("bit_serial_mult_sat: fraction width exceeds operand width");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_SIGN = 3'd1,
      W_MAG  = 3'd2,
      ROUND  = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t             state;
   logic               nsign;
   logic [MAG_W-1:0]   nmag;
   logic               rsign;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               in_ready_q;
   logic               busy_q;
   logic               out_valid_q;
   logic [DATA_W-1:0]  out_data_q;
   logic               out_sat_q;

   logic               rnd_bit;
   logic [SUM_W-1:0]   m_full;
   logic               sat;
   logic [MAG_W-1:0]   res_mag;
   logic               res_sign;

   // Round-half-up term is the first discarded fraction bit; absent for integer weights.
   if (WFRAC_W > 0) begin : g_rnd
      assign rnd_bit = acc[WFRAC_W-1];
   end else begin : g_no_rnd
      assign rnd_bit = 1'b0;
   end

   // Scale back to neuron format, clip to max magnitude, and suppress negative zero.
   always_comb begin
      m_full   = ({1'b0, acc} >> WFRAC_W) + SUM_W'(rnd_bit);
      sat      = |m_full[SUM_W-1:MAG_W];
      res_mag  = sat ? {MAG_W{1'b1}} : m_full[MAG_W-1:0];
      res_sign = rsign & (|res_mag);
   end

   // Sequencer: capture operand, shift-add one weight bit per valid cycle, round, hold result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         nsign       <= 1'b0;
         nmag        <= '0;
         rsign       <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  nsign      <= bus.in_neuron[DATA_W-1];
                  nmag       <= bus.in_neuron[MAG_W-1:0];
                  acc        <= '0;
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= W_SIGN;
               end
            end
            W_SIGN: begin
               if (bus.w_valid) begin
                  rsign <= nsign ^ bus.w_bit;
                  state <= W_MAG;
               end
            end
            W_MAG: begin
               if (bus.w_valid) begin
                  acc <= (acc << 1) + (bus.w_bit ? ACC_W'(nmag) : '0);
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BIT) begin
                     state <= ROUND;
                  end
               end
            end
            ROUND: begin
               out_data_q  <= {res_sign, res_mag};
               out_sat_q   <= sat;
               out_valid_q <= 1'b1;
               state       <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_bit_serial_mult_sat.sv
// Purpose: directed vectors for bit_serial_mult_sat with a queue-based scoreboard.
// Latency: expects out_valid WGT_W+2 cycles after accept plus one per weight stall.
// Backpressure: consumer holds out_ready low for a per-operation number of cycles.
module tb_bit_serial_mult_sat;
   localparam int DATA_W = 16;
   localparam int WGT_W  = 16;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sat;
      int                t_acc;
      int                lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bit_serial_mult_sat_if #(.DATA_W(DATA_W)) bus ();

   bit_serial_mult_sat #(
      .DATA_W (DATA_W),
      .FRAC_W (10),
      .WGT_W  (WGT_W),
      .WFRAC_W(10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ready_hold = 0;
   int   wait_cnt = 0;

   // Free-running cycle index; after posedge k it reads k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Consumer: hold out_ready low for ready_hold cycles once a result appears.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.out_valid && wait_cnt < ready_hold) begin
            bus.out_ready = 1'b0;
            wait_cnt++;
         end else begin
            bus.out_ready = 1'b1;
            if (!bus.out_valid) wait_cnt = 0;
         end
      end
   end

   // Monitor: compare each presented result with the head of the scoreboard.
   bit                seen = 1'b0;
   logic [DATA_W-1:0] held_data;
   logic              held_sat;
   always @(negedge clk) begin
      if (reset && bus.out_valid) begin
         if (!seen) begin
            seen      = 1'b1;
            held_data = bus.out_data;
            held_sat  = bus.out_sat;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got 0x%0h, expected no result", bus.out_data);
            end else begin
               check("latency", cyc + 1 - exp_q[0].t_acc, exp_q[0].lat);
               check("out_data", bus.out_data, exp_q[0].data);
               check("out_sat", bus.out_sat, exp_q[0].sat);
            end
         end else begin
            check("out_data_stable", bus.out_data, held_data);
            check("out_sat_stable", bus.out_sat, held_sat);
            check("in_ready_in_out", bus.in_ready, 1'b0);
         end
         if (bus.out_ready) begin
            seen = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_idle(output bit ok);
      int k = 0;
      while (!bus.in_ready && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      ok = bus.in_ready;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
      end
   endtask

   // Issue one operand, queue its expected result, then stream sign + magnitude bits.
   task automatic run_op(input logic [DATA_W-1:0] neuron, input logic wsign,
                         input logic [WGT_W-2:0] wmag, input logic [WGT_W-1:0] stalls,
                         input logic [DATA_W-1:0] exp_data, input logic exp_sat, input int hold);
      bit   ok;
      exp_t e;
      wait_idle(ok);
      if (!ok) return;
      ready_hold    = hold;
      bus.in_valid  = 1'b1;
      bus.in_neuron = neuron;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_neuron = '1;
      e.data  = exp_data;
      e.sat   = exp_sat;
      e.t_acc = cyc;
      e.lat   = WGT_W + 2 + $countones(stalls);
      exp_q.push_back(e);
      check("busy_after_accept", bus.busy, 1'b1);
      check("in_ready_after_accept", bus.in_ready, 1'b0);
      for (int i = 0; i < WGT_W; i++) begin
         if (stalls[i]) begin
            bus.w_valid = 1'b0;
            bus.w_bit   = 1'b1;
            @(posedge clk);
            #1;
         end
         bus.w_valid = 1'b1;
         bus.w_bit   = (i == 0) ? wsign : wmag[WGT_W-1-i];
         @(posedge clk);
         #1;
      end
      bus.w_valid = 1'b0;
      bus.w_bit   = 1'b0;
   endtask

   initial begin
      bit ok;
      int k;
      bus.in_valid  = 1'b0;
      bus.in_neuron = '0;
      bus.w_valid   = 1'b0;
      bus.w_bit     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_out_data", bus.out_data, 16'h0000);
      check("rst_out_sat", bus.out_sat, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      //     neuron    ws    wmag      stalls    exp       sat hold
      run_op(16'h0600, 1'b0, 15'h0800, 16'h0000, 16'h0C00, 1'b0, 0);
      run_op(16'h8600, 1'b0, 15'h0800, 16'h0000, 16'h8C00, 1'b0, 0);
      run_op(16'h8600, 1'b1, 15'h0800, 16'h0000, 16'h0C00, 1'b0, 0);
      run_op(16'h7C00, 1'b0, 15'h1000, 16'h0000, 16'h7FFF, 1'b1, 0);
      run_op(16'h7C00, 1'b1, 15'h1000, 16'h0000, 16'hFFFF, 1'b1, 1);
      run_op(16'h0001, 1'b0, 15'h0200, 16'h0000, 16'h0001, 1'b0, 0);
      run_op(16'h8001, 1'b0, 15'h0000, 16'h0000, 16'h0000, 1'b0, 0);
      run_op(16'h0600, 1'b0, 15'h0800, 16'h0411, 16'h0C00, 1'b0, 5);

      // Abort an operation mid-magnitude with reset; nothing may come out of it.
      wait_idle(ok);
      if (ok) begin
         bus.in_valid  = 1'b1;
         bus.in_neuron = 16'h7C00;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.w_valid  = 1'b1;
         for (int i = 0; i < 6; i++) begin
            bus.w_bit = 1'b1;
            @(posedge clk);
            #1;
         end
         reset = 1'b0;
         @(posedge clk);
         #1;
         check("abort_out_valid", bus.out_valid, 1'b0);
         check("abort_busy", bus.busy, 1'b0);
         check("abort_in_ready", bus.in_ready, 1'b1);
         check("abort_out_data", bus.out_data, 16'h0000);
         reset       = 1'b1;
         bus.w_valid = 1'b0;
         bus.w_bit   = 1'b0;
         @(posedge clk);
         #1;
         run_op(16'h0600, 1'b0, 15'h0800, 16'h0000, 16'h0C00, 1'b0, 0);
      end

      k = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (exp_q.size() != 0 || bus.out_valid) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
